nmcu_instr_frontend: RTL and testbench



---
 rtl/nmcu_instr_frontend.sv | 215 +++++++++++++++++++++
 tb/tb_nmcu_instr_frontend.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_instr_frontend.sv
// NMCU CPU instruction front end: host queue, opcode/length checks,
// single-issue dispatch to the control unit, one response per instruction.

package nmcu_pkg;
   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 32;
   localparam int LEN_WIDTH  = 8;
endpackage

package instr_pkg;
   import nmcu_pkg::*;

   typedef enum logic [3:0] {
      INSTR_NOP   = 4'd0,
      INSTR_STORE = 4'd1,
      INSTR_LOAD  = 4'd2,
      INSTR_MAC   = 4'd3
   } opcode_t;

   typedef struct packed {
      opcode_t                 opcode;
      logic [ADDR_WIDTH-1:0]   addr_a;
      logic [ADDR_WIDTH-1:0]   addr_b;
      logic [ADDR_WIDTH-1:0]   addr_c;
      logic [DATA_WIDTH-1:0]   data;
      logic [LEN_WIDTH-1:0]    len;
   } instruction_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [1:0]              status;
   } nmcu_cpu_resp_t;
endpackage

module nmcu_instr_frontend
   import nmcu_pkg::*;
   import instr_pkg::*;
#(
   parameter int IQ_DEPTH = 4,
   parameter int MAX_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_instr_valid,
   input  instruction_t          cpu_instruction,
   output logic                  cpu_instr_ready,
   output logic                  nmcu_resp_valid_o,
   input  logic                  nmcu_resp_ready_i,
   output nmcu_cpu_resp_t        nmcu_response_o,
   output logic                  cu_instr_valid_o,
   output instruction_t          cu_instruction_o,
   input  logic                  cu_instr_ready_i,
   input  logic                  cu_done_i,
   input  logic [DATA_WIDTH-1:0] cu_result_i,
   input  logic [1:0]            cu_status_i,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int CW = $clog2(IQ_DEPTH + 1);

   localparam logic [CW-1:0]        LP_DEPTH   = CW'(IQ_DEPTH);
   localparam logic [LEN_WIDTH-1:0] LP_MAX_LEN = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] LP_ONE     = LEN_WIDTH'(1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DISPATCH = 2'd1;
   localparam logic [1:0] S_WAIT_CU  = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

   localparam logic [1:0] ST_BAD_OP  = 2'b01;
   localparam logic [1:0] ST_BAD_LEN = 2'b10;

   instruction_t   r_mem [IQ_DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;
   logic           r_ready;

   logic [1:0]     r_state;
   instruction_t   r_cu_instr;
   nmcu_cpu_resp_t r_resp;
   logic           r_err;

   logic           w_push;
   logic           w_pop;
   logic [CW-1:0]  w_count_nxt;
   instruction_t   w_head;
   logic           w_op_legal;
   logic           w_len_ok;
   logic           w_reject;
   logic [1:0]     w_rej_status;

   // ready is registered, so a full queue refuses pushes even when
   // the head is popped in the same cycle
   assign w_push = cpu_instr_valid & r_ready;
   assign w_pop  = (r_state == S_IDLE) & (r_count != '0);
   assign w_head = r_mem[r_rptr];

   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   // queue storage; flushed logically by resetting pointers and count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= cpu_instruction;
      end
   end

   // queue pointers, occupancy and registered host ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ready <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < LP_DEPTH);
      end
   end

   // opcode and length legality of the queue head
   always_comb begin
      w_op_legal = 1'b0;
      w_len_ok   = 1'b0;
      case (w_head.opcode)
         INSTR_STORE,
         INSTR_LOAD: begin
            w_op_legal = 1'b1;
            w_len_ok   = (w_head.len == LP_ONE);
         end
         INSTR_MAC: begin
            w_op_legal = 1'b1;
            w_len_ok   = (w_head.len != '0) &&
                         (w_head.len <= LP_MAX_LEN);
         end
         default: begin
            w_op_legal = 1'b0;
            w_len_ok   = 1'b0;
         end
      endcase
   end

   assign w_reject     = ~(w_op_legal & w_len_ok);
   assign w_rej_status = w_op_legal ? ST_BAD_LEN : ST_BAD_OP;

   // single-issue sequencer: pop, dispatch, wait, respond
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cu_instr <= '0;
         r_resp     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  if (w_reject) begin
                     r_resp.data   <= '0;
                     r_resp.status <= w_rej_status;
                     r_state       <= S_RESP;
                  end else begin
                     r_cu_instr <= w_head;
                     r_state    <= S_DISPATCH;
                  end
               end
            end
            S_DISPATCH: begin
               if (cu_instr_ready_i) begin
                  r_state <= S_WAIT_CU;
               end
            end
            S_WAIT_CU: begin
               if (cu_done_i) begin
                  r_resp.data   <= cu_result_i;
                  r_resp.status <= cu_status_i;
                  r_state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (nmcu_resp_ready_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // a completion pulse with nothing outstanding is a protocol error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (cu_done_i && (r_state != S_WAIT_CU)) begin
         r_err <= 1'b1;
      end
   end

   assign cpu_instr_ready   = r_ready;
   assign cu_instr_valid_o  = (r_state == S_DISPATCH);
   assign cu_instruction_o  = r_cu_instr;
   assign nmcu_resp_valid_o = (r_state == S_RESP);
   assign nmcu_response_o   = r_resp;
   assign busy_o            = (r_state != S_IDLE) | (r_count != '0);
   assign err_o             = r_err;

endmodule

// File: tb/tb_nmcu_instr_frontend.sv
// Bench for nmcu_instr_frontend: queue-level reference model plus
// directed scenarios with literal expectations.

module tb_nmcu_instr_frontend;
   import nmcu_pkg::*;
   import instr_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cpu_instr_valid;
   instruction_t          cpu_instruction;
   logic                  cpu_instr_ready;
   logic                  nmcu_resp_valid_o;
   logic                  nmcu_resp_ready_i;
   nmcu_cpu_resp_t        nmcu_response_o;
   logic                  cu_instr_valid_o;
   instruction_t          cu_instruction_o;
   logic                  cu_instr_ready_i;
   logic                  cu_done_i;
   logic [DATA_WIDTH-1:0] cu_result_i;
   logic [1:0]            cu_status_i;
   logic                  busy_o;
   logic                  err_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_disp  = 0;
   int n_rv    = 0;

   logic cu_hold   = 1'b0;
   int   stray_req = 0;
   int   stray_ack = 0;

   instruction_t   disp_q [$];
   nmcu_cpu_resp_t resp_q [$];

   nmcu_instr_frontend #(.IQ_DEPTH(4), .MAX_LEN(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_instr_valid   (cpu_instr_valid),
      .cpu_instruction   (cpu_instruction),
      .cpu_instr_ready   (cpu_instr_ready),
      .nmcu_resp_valid_o (nmcu_resp_valid_o),
      .nmcu_resp_ready_i (nmcu_resp_ready_i),
      .nmcu_response_o   (nmcu_response_o),
      .cu_instr_valid_o  (cu_instr_valid_o),
      .cu_instruction_o  (cu_instruction_o),
      .cu_instr_ready_i  (cu_instr_ready_i),
      .cu_done_i         (cu_done_i),
      .cu_result_i       (cu_result_i),
      .cu_status_i       (cu_status_i),
      .busy_o            (busy_o),
      .err_o             (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic instruction_t mk(logic [3:0] op, logic [15:0] a,
                                       logic [15:0] b, logic [15:0] c,
                                       logic [31:0] d, logic [7:0] l);
      instruction_t t;
      t.opcode = opcode_t'(op);
      t.addr_a = a;
      t.addr_b = b;
      t.addr_c = c;
      t.data   = d;
      t.len    = l;
      return t;
   endfunction

   // 0 = legal, 1 = bad opcode, 2 = bad length
   function automatic int classify(instruction_t i);
      case (i.opcode)
         INSTR_STORE, INSTR_LOAD: return (i.len == 8'd1) ? 0 : 2;
         INSTR_MAC: return (i.len >= 8'd1 && i.len <= 8'd16) ? 0 : 2;
         default: return 1;
      endcase
   endfunction

   // the bench CU answers data=instr.data, status=instr.addr_c[1:0]
   function automatic nmcu_cpu_resp_t expect_resp(instruction_t i);
      nmcu_cpu_resp_t r;
      case (classify(i))
         0: begin r.data = i.data; r.status = i.addr_c[1:0]; end
         1: begin r.data = '0;     r.status = 2'b01;         end
         default: begin r.data = '0; r.status = 2'b10;       end
      endcase
      return r;
   endfunction

   // reference model and per-cycle compare (handshakes complete at next rise)
   always @(negedge clk) begin
      if (rst) begin
         disp_q.delete();
         resp_q.delete();
      end else begin
         if (cu_instr_valid_o) begin
            n_tests++;
            if (disp_q.size() == 0) begin
               n_fail++;
               $display("FAIL mdl_dispatch: unexpected %0h", cu_instruction_o);
            end else if (cu_instruction_o !== disp_q[0]) begin
               n_fail++;
               $display("FAIL mdl_dispatch: got %0h expected %0h",
                        cu_instruction_o, disp_q[0]);
            end
            if (cu_instr_ready_i) begin
               n_disp++;
               if (disp_q.size() > 0) void'(disp_q.pop_front());
            end
         end
         if (nmcu_resp_valid_o) begin
            n_rv++;
            n_tests++;
            if (resp_q.size() == 0) begin
               n_fail++;
               $display("FAIL mdl_resp: unexpected %0h", nmcu_response_o);
            end else if (nmcu_response_o !== resp_q[0]) begin
               n_fail++;
               $display("FAIL mdl_resp: got %0h expected %0h",
                        nmcu_response_o, resp_q[0]);
            end
            if (nmcu_resp_ready_i && resp_q.size() > 0)
               void'(resp_q.pop_front());
         end
         if (cpu_instr_valid && cpu_instr_ready) begin
            resp_q.push_back(expect_resp(cpu_instruction));
            if (classify(cpu_instruction) == 0)
               disp_q.push_back(cpu_instruction);
         end
      end
   end

   // control-unit model: always ready, done three cycles after taking work
   initial begin
      instruction_t cur;
      logic         pend;
      int           cnt;
      cur = '0;
      pend = 1'b0;
      cnt = 0;
      cu_instr_ready_i = 1'b1;
      cu_done_i = 1'b0;
      cu_result_i = '0;
      cu_status_i = '0;
      forever begin
         @(negedge clk);
         cu_done_i = 1'b0;
         if (rst) begin
            pend = 1'b0;
            continue;
         end
         if (stray_req != stray_ack) begin
            stray_ack = stray_req;
            cu_done_i = 1'b1;
            cu_result_i = 32'hDEAD;
            cu_status_i = 2'b11;
         end else if (pend && !cu_hold) begin
            if (cnt == 0) begin
               cu_done_i = 1'b1;
               cu_result_i = cur.data;
               cu_status_i = cur.addr_c[1:0];
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
         if (cu_instr_valid_o && cu_instr_ready_i) begin
            pend = 1'b1;
            cnt = 2;
            cur = cu_instruction_o;
         end
      end
   end

   task automatic send(instruction_t ins);
      logic ok;
      ok = 1'b0;
      cpu_instruction = ins;
      cpu_instr_valid = 1'b1;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         ok = cpu_instr_ready;
         @(posedge clk);
         #1;
      end
      cpu_instr_valid = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got ready=0 expected accept");
      end
   endtask

   task automatic wait_resp(output nmcu_cpu_resp_t r);
      logic found;
      found = 1'b0;
      r = '0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (nmcu_resp_valid_o) begin
            found = 1'b1;
            r = nmcu_response_o;
         end
      end
      @(posedge clk);
      #1;
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL resp_timeout: got none expected a response");
      end
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_ready"},   64'(cpu_instr_ready), 64'(0));
      chk({tag, "_rvalid"},  64'(nmcu_resp_valid_o), 64'(0));
      chk({tag, "_resp"},    64'(nmcu_response_o), 64'(0));
      chk({tag, "_cvalid"},  64'(cu_instr_valid_o), 64'(0));
      chk({tag, "_cinstr"},  64'(cu_instruction_o != '0), 64'(0));
      chk({tag, "_busy"},    64'(busy_o), 64'(0));
      chk({tag, "_err"},     64'(err_o), 64'(0));
   endtask

   initial begin
      nmcu_cpu_resp_t r;
      instruction_t   bt [4];
      logic [31:0]    bd [4];
      logic [1:0]     bs [4];
      int d0;
      int rv0;
      int acc;

      rst = 1'b1;
      cpu_instr_valid = 1'b0;
      cpu_instruction = '0;
      nmcu_resp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst0");

      // release reset
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("ready_still_low", 64'(cpu_instr_ready), 64'(0));
      @(posedge clk);
      #1;
      chk("ready_rise", 64'(cpu_instr_ready), 64'(1));

      // STORE addr_a=5 data=7 len=1
      send(mk(4'd1, 16'd5, 16'd0, 16'd0, 32'd7, 8'd1));
      chk("store_no_early_disp", 64'(cu_instr_valid_o), 64'(0));
      @(posedge clk);
      #1;
      chk("store_disp_lat", 64'(cu_instr_valid_o), 64'(1));
      wait_resp(r);
      chk("store_data", 64'(r.data), 64'(7));
      chk("store_status", 64'(r.status), 64'(0));

      // undefined opcodes
      d0 = n_disp;
      send(mk(4'hF, 16'd1, 16'd2, 16'd3, 32'd99, 8'd1));
      wait_resp(r);
      chk("illegal_status", 64'(r.status), 64'(2'b01));
      chk("illegal_data", 64'(r.data), 64'(0));
      send(mk(4'h0, 16'd1, 16'd2, 16'd3, 32'd98, 8'd1));
      wait_resp(r);
      chk("nop_status", 64'(r.status), 64'(2'b01));
      chk("illegal_no_disp", 64'(n_disp), 64'(d0));

      // MAC len=0 then legal MAC, responses in order
      send(mk(4'd3, 16'd0, 16'd100, 16'd200, 32'd55, 8'd0));
      send(mk(4'd3, 16'd0, 16'd100, 16'd200, 32'd90, 8'd4));
      wait_resp(r);
      chk("mac0_status", 64'(r.status), 64'(2'b10));
      chk("mac0_data", 64'(r.data), 64'(0));
      chk("mac0_no_disp", 64'(n_disp), 64'(d0));
      wait_resp(r);
      chk("mac4_data", 64'(r.data), 64'(90));
      chk("mac4_status", 64'(r.status), 64'(0));

      // length boundaries and status pass-through
      bt[0] = mk(4'd3, 16'd1, 16'd2, 16'd0, 32'd3,  8'd16);
      bd[0] = 32'd3;  bs[0] = 2'b00;
      bt[1] = mk(4'd3, 16'd1, 16'd2, 16'd0, 32'd4,  8'd17);
      bd[1] = 32'd0;  bs[1] = 2'b10;
      bt[2] = mk(4'd2, 16'd9, 16'd0, 16'd0, 32'd5,  8'd2);
      bd[2] = 32'd0;  bs[2] = 2'b10;
      bt[3] = mk(4'd2, 16'd9, 16'd0, 16'd2, 32'd33, 8'd1);
      bd[3] = 32'd33; bs[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         send(bt[i]);
         wait_resp(r);
         chk($sformatf("bnd%0d_data", i), 64'(r.data), 64'(bd[i]));
         chk($sformatf("bnd%0d_status", i), 64'(r.status), 64'(bs[i]));
      end

      // full queue: 1 in flight + 4 queued
      cu_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(mk(4'd2, 16'(200 + i), 16'd0, 16'd0, 32'(i + 1), 8'd1));
         if (i == 3)
            chk("ready_before_full", 64'(cpu_instr_ready), 64'(1));
      end
      chk("full_ready_low", 64'(cpu_instr_ready), 64'(0));
      cpu_instruction = mk(4'd2, 16'd205, 16'd0, 16'd0, 32'd6, 8'd1);
      cpu_instr_valid = 1'b1;
      acc = 0;
      repeat (4) begin
         @(negedge clk);
         if (cpu_instr_ready) acc++;
      end
      @(posedge clk);
      #1;
      cpu_instr_valid = 1'b0;
      chk("full_refuse_6th", 64'(acc), 64'(0));
      cu_hold = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_resp(r);
         chk($sformatf("full_resp%0d", i), 64'(r.data), 64'(i + 1));
      end

      // response backpressure with 2 entries queued
      nmcu_resp_ready_i = 1'b0;
      for (int i = 0; i < 3; i++)
         send(mk(4'd2, 16'd50, 16'd0, 16'd0, 32'(11 + i), 8'd1));
      r = '0;
      for (int k = 0; k < 40 && !nmcu_resp_valid_o; k++) @(negedge clk);
      r = nmcu_response_o;
      chk("bp_first", 64'(r.data), 64'(11));
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_valid", 64'(nmcu_resp_valid_o), 64'(1));
         chk("bp_stable", 64'(nmcu_response_o), 64'(r));
         chk("bp_no_disp", 64'(cu_instr_valid_o), 64'(0));
      end
      @(posedge clk);
      #1;
      nmcu_resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_no_early_disp", 64'(cu_instr_valid_o), 64'(0));
      @(posedge clk);
      #1;
      chk("bp_next_disp", 64'(cu_instr_valid_o), 64'(1));
      wait_resp(r);
      chk("bp_resp2", 64'(r.data), 64'(12));
      wait_resp(r);
      chk("bp_resp3", 64'(r.data), 64'(13));

      // reset during WAIT_CU with 2 entries queued
      cu_hold = 1'b1;
      for (int i = 0; i < 3; i++)
         send(mk(4'd2, 16'd70, 16'd0, 16'd0, 32'(21 + i), 8'd1));
      repeat (2) @(posedge clk);
      #1;
      chk("mid_busy", 64'(busy_o), 64'(1));
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cu_hold = 1'b0;
      @(posedge clk);
      #1;
      chk("err_before_stray", 64'(err_o), 64'(0));
      rv0 = n_rv;
      stray_req++;
      repeat (4) @(posedge clk);
      #1;
      chk("err_after_stray", 64'(err_o), 64'(1));
      repeat (10) @(posedge clk);
      #1;
      chk("no_resp_after_rst", 64'(n_rv), 64'(rv0));
      chk("idle_after_rst", 64'(busy_o), 64'(0));
      chk("no_disp_after_rst", 64'(cu_instr_valid_o), 64'(0));
      chk("err_sticky", 64'(err_o), 64'(1));

      chk("drain_resp_q", 64'(resp_q.size()), 64'(0));
      chk("drain_disp_q", 64'(disp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of run");
      $fatal(1, "watchdog");
   end

endmodule
